// File: rtl/sc_meter_pkg.sv
// Shared types and helpers for the bitstream correlation meter.
package sc_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    CALC  = 2'd2
  } state_t;

  // Counter width able to hold the value win itself.
  function automatic int unsigned cw_f(input int unsigned win);
    return $clog2(win + 1);
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Enabled ones counter with synchronous clear; din=1 turns it into a sample counter.
module sc_ones_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          din,
  output logic [CW-1:0] count
);

  // Clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && din) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sc_corr_meter.sv
// Windowed correlation meter: counts ones in x, y and x&y over WIN_LEN valid
// pairs, then classifies the pair's SCC sign and extremes in one CALC cycle.
module sc_corr_meter
  import sc_meter_pkg::*;
#(
  parameter int unsigned WIN_LEN = 256,
  localparam int unsigned CW = cw_f(WIN_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic          x,
  input  logic          y,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt_x,
  output logic [CW-1:0] cnt_y,
  output logic [CW-1:0] cnt_and,
  output logic          corr_pos,
  output logic          corr_neg,
  output logic          scc_max,
  output logic          scc_min
);

  localparam int unsigned PW = 2 * CW;
  localparam int unsigned SW = CW + 1;

  state_t          state;
  logic            clr_c;
  logic            en_c;
  logic [CW-1:0]   x_ones;
  logic [CW-1:0]   y_ones;
  logic [CW-1:0]   and_ones;
  logic [CW-1:0]   smp_cnt;

  logic [PW-1:0]   prod_and_c;
  logic [PW-1:0]   prod_xy_c;
  logic [SW-1:0]   sum_c;
  logic [CW-1:0]   min_c;
  logic [CW-1:0]   max_c;
  logic [CW-1:0]   bound_c;

  // A pair arriving together with start is not part of the window.
  assign clr_c = (state == IDLE) && start;
  assign en_c  = (state == COUNT) && in_valid;

  sc_ones_counter #(.CW(CW)) u_cnt_x (
    .clk(clk), .rst(rst), .clr(clr_c), .en(en_c), .din(x), .count(x_ones)
  );

  sc_ones_counter #(.CW(CW)) u_cnt_y (
    .clk(clk), .rst(rst), .clr(clr_c), .en(en_c), .din(y), .count(y_ones)
  );

  sc_ones_counter #(.CW(CW)) u_cnt_and (
    .clk(clk), .rst(rst), .clr(clr_c), .en(en_c), .din(x & y), .count(and_ones)
  );

  sc_ones_counter #(.CW(CW)) u_cnt_smp (
    .clk(clk), .rst(rst), .clr(clr_c), .en(en_c), .din(1'b1), .count(smp_cnt)
  );

  // Classification arithmetic on the held counters; bound never wraps below zero.
  always_comb begin
    prod_and_c = PW'(and_ones) * PW'(WIN_LEN);
    prod_xy_c  = PW'(x_ones) * PW'(y_ones);
    sum_c      = SW'(x_ones) + SW'(y_ones);
    min_c      = (x_ones < y_ones) ? x_ones : y_ones;
    max_c      = (x_ones < y_ones) ? y_ones : x_ones;
    bound_c    = '0;
    if (sum_c > SW'(WIN_LEN)) begin
      bound_c = CW'(sum_c - SW'(WIN_LEN));
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt_x    <= '0;
      cnt_y    <= '0;
      cnt_and  <= '0;
      corr_pos <= 1'b0;
      corr_neg <= 1'b0;
      scc_max  <= 1'b0;
      scc_min  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= COUNT;
            busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (in_valid && (smp_cnt == CW'(WIN_LEN - 1))) begin
            state <= CALC;
          end
        end
        CALC: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          cnt_x    <= x_ones;
          cnt_y    <= y_ones;
          cnt_and  <= and_ones;
          corr_pos <= (prod_and_c > prod_xy_c);
          corr_neg <= (prod_and_c < prod_xy_c);
          scc_max  <= (and_ones == min_c);
          scc_min  <= (and_ones == bound_c);
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_corr_meter.sv
// Directed bench for sc_corr_meter at WIN_LEN=8, bitstreams MSB-first.
module tb_sc_corr_meter;

  localparam int unsigned WIN_LEN = 8;
  localparam int unsigned CW      = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          x;
  logic          y;
  logic          busy;
  logic          done;
  logic [CW-1:0] cnt_x;
  logic [CW-1:0] cnt_y;
  logic [CW-1:0] cnt_and;
  logic          corr_pos;
  logic          corr_neg;
  logic          scc_max;
  logic          scc_min;

  int n_cmp  = 0;
  int n_bad  = 0;
  int done_seen = 0;

  sc_corr_meter #(.WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .x(x), .y(y),
    .busy(busy), .done(done), .cnt_x(cnt_x), .cnt_y(cnt_y), .cnt_and(cnt_and),
    .corr_pos(corr_pos), .corr_neg(corr_neg), .scc_max(scc_max), .scc_min(scc_min)
  );

  always #5 clk = ~clk;

  // Counts cycles in which done was high (value before the edge's update).
  always @(posedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic chk_results(input string tag, input int ex, input int ey, input int ea,
                             input logic [3:0] fl);
    chk({tag, "_cnt_x"},    32'(cnt_x),    32'(ex));
    chk({tag, "_cnt_y"},    32'(cnt_y),    32'(ey));
    chk({tag, "_cnt_and"},  32'(cnt_and),  32'(ea));
    chk({tag, "_corr_pos"}, 32'(corr_pos), 32'(fl[3]));
    chk({tag, "_corr_neg"}, 32'(corr_neg), 32'(fl[2]));
    chk({tag, "_scc_max"},  32'(scc_max),  32'(fl[1]));
    chk({tag, "_scc_min"},  32'(scc_min),  32'(fl[0]));
  endtask

  // One full window; fl = {corr_pos, corr_neg, scc_max, scc_min}.
  task automatic run_window(input string tag, input logic [7:0] xp, input logic [7:0] yp,
                            input bit gaps, input int ex, input int ey, input int ea,
                            input logic [3:0] fl);
    int d0;
    d0 = done_seen;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; x = 1'b1; y = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; x = xp[7-i]; y = yp[7-i];
      @(negedge clk);
      if (gaps && (i == 1 || i == 4)) begin
        in_valid = 1'b0; x = 1'b1; y = 1'b1; start = (i == 1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    in_valid = 1'b0; x = 1'b0; y = 1'b0;
    start = gaps;
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk_results(tag, ex, ey, ea, fl);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; x = 1'b0; y = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk_results("reset", 0, 0, 0, 4'b0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_window("pos",    8'b11110000, 8'b11000000, 1'b0, 4, 2, 2, 4'b1010);
    run_window("neg",    8'b11110000, 8'b00001100, 1'b0, 4, 2, 0, 4'b0101);
    run_window("unc",    8'b10101010, 8'b11001100, 1'b0, 4, 4, 2, 4'b0000);
    run_window("gapped", 8'b10101010, 8'b11001100, 1'b1, 4, 4, 2, 4'b0000);
    run_window("ones",   8'b11111111, 8'b11111111, 1'b0, 8, 8, 8, 4'b0011);

    // Abort a window with reset after four samples.
    d0 = done_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x = 1'b1; y = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk_results("abort", 0, 0, 0, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 32'(done_seen - d0), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    run_window("fresh",  8'b11110000, 8'b11000000, 1'b0, 4, 2, 2, 4'b1010);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
